load_data_unit: RTL and testbench
=================================

Name: load_data_unit

Overview:
- Parametrised successor to the CPU's memory data-register stage.
- Issues one Avalon-style read per request and holds `read` until the slave drops `waitrequest`.
- Captures the returned word, then applies MIPS load extraction (LB/LBU/LH/LHU/LW/LWL/LWR) with a register merge.
- Sits between the multicycle CPU controller (MEM state) and the register-file write-back mux. Adds a wait-timeout error.

Parameters:
- DATA_WIDTH, 32, bus word width; only 32 is legal (lane logic is 4-byte).
- MAX_WAIT, 255, max cycles `read` may stall on `waitrequest` before error; 1..65535.
- WAIT_CNT_W, 16, width of the wait counter; must hold MAX_WAIT.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request pulse from the controller
- load_type  in  3  0=LB 1=LBU 2=LH 3=LHU 4=LW 5=LWL 6=LWR; 7 treated as LW
- addr_lo  in  2  byte offset within word; sampled on accepted start
- rt_old  in  32  current rt value for LWL/LWR merge; sampled on accepted start
- waitrequest  in  1  slave stall
- readdata  in  32  slave read data; valid in the cycle `read`=1 and `waitrequest`=0
- read  out  1  bus read strobe
- busy  out  1  high in REQ
- data_valid  out  1  extracted result is valid
- dr_readdata  out  32  extracted/merged load result
- raw_data  out  32  unmodified captured word
- timeout_err  out  1  sticky: MAX_WAIT exceeded

Behaviour:
- Clock and reset: single clock `clk`; reset is synchronous and active-high, named `reset`.
- Reset values: state=IDLE; read=0; busy=0; data_valid=0; dr_readdata=0; raw_data=0; timeout_err=0; wait counter=0.
- Reset applies from any state, including mid-REQ: `read` drops the next cycle and no capture occurs.
- FSM states: IDLE, REQ, DONE, ERR.
- IDLE:
  - start=1 → REQ. Latch load_type, addr_lo and rt_old; clear data_valid; counter=0.
  - Otherwise remain in IDLE.
- REQ:
  - `read`=1 (registered, so it rises the cycle after start).
  - waitrequest=0 → capture readdata into raw_data, compute dr_readdata, go to DONE.
  - Capture latency: result visible the cycle after acceptance. Zero-wait slave: start at cycle 0 → read at cycle 1 → data_valid at cycle 2.
  - waitrequest=1 → counter+1. When the counter reaches MAX_WAIT while waitrequest is still 1 → ERR.
  - start while in REQ is ignored: no re-latch, no second read.
- DONE:
  - read=0, data_valid=1.
  - dr_readdata and raw_data are held until the next accepted start.
  - start=1 → REQ, same actions as from IDLE; data_valid falls the same edge.
- ERR:
  - read=0, timeout_err=1, data_valid=0.
  - Leave only via reset. start is ignored.
- Extraction (little-endian; byte k = readdata[8k+7:8k], o=addr_lo):
  - LB/LBU: byte o, sign- or zero-extended.
  - LH/LHU: halfword at bytes {o[1],0} and {o[1],1}, sign- or zero-extended. o[0] is ignored (no alignment trap).
  - LW: whole word.
  - LWL: (word << 8*(3-o)) | (rt_old & ((1 << 8*(3-o)) - 1)).
  - LWR: (word >> 8*o) | (rt_old & ~(32'hFFFFFFFF >> 8*o)).
- readdata is sampled only in the acceptance cycle. Values on readdata at any other time, including X, never reach dr_readdata.
- Simultaneous waitrequest=0 and counter==MAX_WAIT in REQ: acceptance wins, go to DONE.

Decomposition:
- Shared package `mips_pkg`:
  - `load_type_t` enum with the codes above.
  - `ldu_state_t` enum.
  - Constants LB..LWR.
- Sub-module `load_extract`: purely combinational (word, load_type, addr_lo, rt_old → result), reusable by a future cache path.
- FSM, counter and registers stay in `load_data_unit`.

Test Plan:
- Zero-wait LW: start with load_type=4, readdata=32'hDEADBEEF, waitrequest=0 → read high for 1 cycle; data_valid=1 two cycles after start; dr_readdata=32'hDEADBEEF.
- 3-cycle stall LB, addr_lo=3: readdata=32'h80FF_0000 on acceptance, waitrequest=1 for 3 cycles → read held 4 cycles; dr_readdata=32'hFFFFFF80. Same stimulus with LBU → 32'h00000080.
- LH/LHU, addr_lo=2, word=32'h8001_1234 → LH gives 32'hFFFF8001, LHU gives 32'h00008001.
- LWL o=1, word=32'h44332211, rt_old=32'hAABBCCDD → 32'h2211CCDD. LWR o=2 with the same inputs → 32'hAABB4433.
- Timeout with MAX_WAIT=4, waitrequest stuck at 1 → ERR after 4 stall cycles; read=0; timeout_err=1; start ignored. Reset → all outputs 0.
- Reset mid-REQ, then start with no wait → read=0 the cycle after reset; the following start completes normally. A start pulsed during REQ produces no extra read.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS load definitions: load-type codes, load-unit FSM states and
// plain constants for code that handles load_type as raw bits.
package mips_pkg;

  typedef enum logic [2:0] {
    LT_LB  = 3'd0,
    LT_LBU = 3'd1,
    LT_LH  = 3'd2,
    LT_LHU = 3'd3,
    LT_LW  = 3'd4,
    LT_LWL = 3'd5,
    LT_LWR = 3'd6,
    LT_LW7 = 3'd7   // reserved code, behaves as LW
  } load_type_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } ldu_state_t;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LBU = 3'd1;
  localparam logic [2:0] LH  = 3'd2;
  localparam logic [2:0] LHU = 3'd3;
  localparam logic [2:0] LW  = 3'd4;
  localparam logic [2:0] LWL = 3'd5;
  localparam logic [2:0] LWR = 3'd6;

endpackage

// File: rtl/load_extract.sv
// Combinational MIPS load extraction (little-endian lanes) with LWL/LWR
// merge against the old rt value. Shared by the bus path and future cache path.
module load_extract
  import mips_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  load_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rt_old,
  output logic [31:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [4:0]  shl_s;
  logic [4:0]  shr_s;
  logic [31:0] lwl_s;
  logic [31:0] lwr_s;

  // Select lanes, build the unaligned-merge candidates, then pick by load type.
  always_comb begin
    byte_s = word[{addr_lo, 3'b000} +: 8];
    // addr_lo[0] is deliberately ignored: halfwords are never trapped.
    half_s = word[{addr_lo[1], 4'b0000} +: 16];
    shl_s  = {2'd3 - addr_lo, 3'b000};
    shr_s  = {addr_lo, 3'b000};
    lwl_s  = (word << shl_s) | (rt_old & ((32'd1 << shl_s) - 32'd1));
    lwr_s  = (word >> shr_s) | (rt_old & ~(32'hFFFF_FFFF >> shr_s));
    case (load_type_t'(load_type))
      LT_LB:   result = {{24{byte_s[7]}}, byte_s};
      LT_LBU:  result = {24'h00_0000, byte_s};
      LT_LH:   result = {{16{half_s[15]}}, half_s};
      LT_LHU:  result = {16'h0000, half_s};
      LT_LWL:  result = lwl_s;
      LT_LWR:  result = lwr_s;
      default: result = word;
    endcase
  end

endmodule

// File: rtl/load_data_unit.sv
// Memory data-register stage: issues one Avalon-style read per request,
// captures the returned word, extracts/merges the load result and flags
// a sticky error when the slave stalls longer than MAX_WAIT cycles.
module load_data_unit
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 255,
  parameter int WAIT_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            load_type,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] rt_old,
  input  logic                  waitrequest,
  input  logic [DATA_WIDTH-1:0] readdata,
  output logic                  read,
  output logic                  busy,
  output logic                  data_valid,
  output logic [DATA_WIDTH-1:0] dr_readdata,
  output logic [DATA_WIDTH-1:0] raw_data,
  output logic                  timeout_err
);

  localparam logic [WAIT_CNT_W-1:0] MAX_WAIT_C = WAIT_CNT_W'(MAX_WAIT);

  ldu_state_t            state_q, state_d;
  logic [2:0]            lt_q, lt_d;
  logic [1:0]            off_q, off_d;
  logic [DATA_WIDTH-1:0] rt_q, rt_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  read_q, read_d;
  logic                  busy_q, busy_d;
  logic                  dv_q, dv_d;
  logic [DATA_WIDTH-1:0] dr_q, dr_d;
  logic [DATA_WIDTH-1:0] raw_q, raw_d;
  logic                  to_q, to_d;
  logic                  accept_s;
  logic [DATA_WIDTH-1:0] ext_s;

  // Request parameters are latched, so readdata is the only live input here.
  load_extract u_extract (
    .word      (readdata),
    .load_type (lt_q),
    .addr_lo   (off_q),
    .rt_old    (rt_q),
    .result    (ext_s)
  );

  // Next-state and next-output logic; all outputs are registered from state_d.
  always_comb begin
    state_d  = state_q;
    lt_d     = lt_q;
    off_d    = off_q;
    rt_d     = rt_q;
    cnt_d    = cnt_q;
    dr_d     = dr_q;
    raw_d    = raw_q;
    accept_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept_s = 1'b1;
        end else begin
          accept_s = 1'b0;
        end
      end
      ST_REQ: begin
        // Acceptance takes priority over the timeout check.
        if (!waitrequest) begin
          state_d = ST_DONE;
          raw_d   = readdata;
          dr_d    = ext_s;
        end else if (cnt_q == MAX_WAIT_C) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (accept_s) begin
      state_d = ST_REQ;
      lt_d    = load_type;
      off_d   = addr_lo;
      rt_d    = rt_old;
      cnt_d   = {WAIT_CNT_W{1'b0}};
    end else begin
      state_d = state_d;
    end
    read_d = (state_d == ST_REQ);
    busy_d = (state_d == ST_REQ);
    dv_d   = (state_d == ST_DONE);
    to_d   = to_q | (state_d == ST_ERR);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      lt_q    <= 3'd0;
      off_q   <= 2'd0;
      rt_q    <= {DATA_WIDTH{1'b0}};
      cnt_q   <= {WAIT_CNT_W{1'b0}};
      read_q  <= 1'b0;
      busy_q  <= 1'b0;
      dv_q    <= 1'b0;
      dr_q    <= {DATA_WIDTH{1'b0}};
      raw_q   <= {DATA_WIDTH{1'b0}};
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lt_q    <= lt_d;
      off_q   <= off_d;
      rt_q    <= rt_d;
      cnt_q   <= cnt_d;
      read_q  <= read_d;
      busy_q  <= busy_d;
      dv_q    <= dv_d;
      dr_q    <= dr_d;
      raw_q   <= raw_d;
      to_q    <= to_d;
    end
  end

  assign read        = read_q;
  assign busy        = busy_q;
  assign data_valid  = dv_q;
  assign dr_readdata = dr_q;
  assign raw_data    = raw_q;
  assign timeout_err = to_q;

endmodule

// File: tb/tb_load_data_unit.sv
// Self-checking bench for load_data_unit: transaction-level timeline model
// plus byte-array extraction model, randomized loads with random stalls.
module tb_load_data_unit;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        reset, start, waitrequest;
  logic [2:0]  load_type;
  logic [1:0]  addr_lo;
  logic [31:0] rt_old, readdata;
  logic        read, busy, data_valid, timeout_err;
  logic [31:0] dr_readdata, raw_data;

  int n_pass  = 0;
  int n_total = 0;

  logic        e_read, e_busy, e_dv, e_to;
  logic [31:0] e_dr, e_raw;
  bit          chk_en = 1'b0;
  logic [31:0] held_dr = 32'd0;
  logic [31:0] held_raw = 32'd0;

  always #5 clk = ~clk;

  load_data_unit #(
    .DATA_WIDTH (32),
    .MAX_WAIT   (MW),
    .WAIT_CNT_W (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .load_type   (load_type),
    .addr_lo     (addr_lo),
    .rt_old      (rt_old),
    .waitrequest (waitrequest),
    .readdata    (readdata),
    .read        (read),
    .busy        (busy),
    .data_valid  (data_valid),
    .dr_readdata (dr_readdata),
    .raw_data    (raw_data),
    .timeout_err (timeout_err)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference extraction computed byte by byte from the load rules.
  function automatic logic [31:0] model(input int lt, input int o,
                                        input logic [31:0] rt, input logic [31:0] w);
    int b[4];
    int r[4];
    int res[4];
    int v;
    logic [31:0] out;
    for (int i = 0; i < 4; i++) begin
      b[i] = int'(w[8*i +: 8]);
      r[i] = int'(rt[8*i +: 8]);
    end
    case (lt)
      0: begin v = b[o]; if (v > 127) v = v - 256; return v; end
      1: return b[o];
      2: begin v = b[2*(o/2)] + 256*b[2*(o/2)+1]; if (v > 32767) v = v - 65536; return v; end
      3: return b[2*(o/2)] + 256*b[2*(o/2)+1];
      5: for (int i = 0; i < 4; i++) res[i] = (i >= 3-o) ? b[i-(3-o)] : r[i];
      6: for (int i = 0; i < 4; i++) res[i] = (i <= 3-o) ? b[i+o] : r[i];
      default: return w;
    endcase
    out = 32'd0;
    for (int i = 0; i < 4; i++) out = out | (32'(res[i]) << (8*i));
    return out;
  endfunction

  // Compare all outputs just after every rising edge once checking is enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        check32("read",        {31'd0, read},        {31'd0, e_read});
        check32("busy",        {31'd0, busy},        {31'd0, e_busy});
        check32("data_valid",  {31'd0, data_valid},  {31'd0, e_dv});
        check32("timeout_err", {31'd0, timeout_err}, {31'd0, e_to});
        check32("dr_readdata", dr_readdata, e_dr);
        check32("raw_data",    raw_data,    e_raw);
      end
    end
  end

  // One cycle: drive inputs at the falling edge and state what the outputs
  // must be after the following rising edge. Unsampled inputs get garbage.
  task automatic step(input logic rst, input logic st, input logic wr, input logic [31:0] rd,
                      input logic er, input logic eb, input logic edv, input logic eto,
                      input logic [31:0] edr, input logic [31:0] eraw);
    @(negedge clk);
    reset       = rst;
    start       = st;
    waitrequest = wr;
    readdata    = rd;
    load_type   = 3'($urandom);
    addr_lo     = 2'($urandom);
    rt_old      = $urandom;
    e_read = er; e_busy = eb; e_dv = edv; e_to = eto; e_dr = edr; e_raw = eraw;
    chk_en = 1'b1;
  endtask

  task automatic txn(input int lt, input int o, input logic [31:0] rt, input logic [31:0] w,
                     input int stalls, input int gap, input bit use_lit, input logic [31:0] lit);
    logic [31:0] exp;
    exp = model(lt, o, rt, w);
    if (use_lit) check32("model_pin", exp, lit);
    step(1'b0, 1'b1, 1'($urandom), $urandom, 1'b1, 1'b1, 1'b0, 1'b0, held_dr, held_raw);
    load_type = 3'(lt);
    addr_lo   = 2'(o);
    rt_old    = rt;
    for (int k = 1; k <= stalls; k++)
      step(1'b0, 1'($urandom), 1'b1, $urandom, 1'b1, 1'b1, 1'b0, 1'b0, held_dr, held_raw);
    step(1'b0, 1'b0, 1'b0, w, 1'b0, 1'b0, 1'b1, 1'b0, exp, w);
    held_dr  = exp;
    held_raw = w;
    for (int j = 0; j < gap; j++)
      step(1'b0, 1'b0, 1'($urandom), $urandom, 1'b0, 1'b0, 1'b1, 1'b0, held_dr, held_raw);
  endtask

  task automatic idle_zero(input logic rst);
    step(rst, 1'b0, 1'($urandom), $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    held_dr  = 32'd0;
    held_raw = 32'd0;
  endtask

  // Bound the whole run in time.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; waitrequest = 1'b1; readdata = 32'd0;
    load_type = 3'd0; addr_lo = 2'd0; rt_old = 32'd0;
    idle_zero(1'b1);
    idle_zero(1'b1);
    idle_zero(1'b0);
    idle_zero(1'b0);

    // Directed loads with hand-computed results.
    txn(4, 0, $urandom, 32'hDEAD_BEEF, 0, 2, 1'b1, 32'hDEAD_BEEF);
    txn(0, 3, $urandom, 32'h80FF_0000, 3, 1, 1'b1, 32'hFFFF_FF80);
    txn(1, 3, $urandom, 32'h80FF_0000, 3, 0, 1'b1, 32'h0000_0080);
    txn(2, 2, $urandom, 32'h8001_1234, 0, 1, 1'b1, 32'hFFFF_8001);
    txn(3, 2, $urandom, 32'h8001_1234, 1, 1, 1'b1, 32'h0000_8001);
    txn(2, 3, $urandom, 32'h8001_1234, 0, 0, 1'b1, 32'hFFFF_8001);
    txn(5, 1, 32'hAABB_CCDD, 32'h4433_2211, 0, 1, 1'b1, 32'h2211_CCDD);
    txn(6, 2, 32'hAABB_CCDD, 32'h4433_2211, 2, 1, 1'b1, 32'hAABB_4433);
    txn(7, 1, $urandom, 32'h1234_5678, 0, 1, 1'b1, 32'h1234_5678);
    // Longest legal stall: acceptance coincides with the wait limit.
    txn(4, 0, $urandom, 32'hCAFE_F00D, MW, 1, 1'b1, 32'hCAFE_F00D);

    // Randomized loads, stalls up to the limit, back-to-back or spaced.
    for (int n = 0; n < 200; n++)
      txn($urandom_range(0, 7), $urandom_range(0, 3), $urandom, $urandom,
          $urandom_range(0, MW), $urandom_range(0, 2), 1'b0, 32'd0);

    // Reset in the middle of a request: no capture, read drops.
    step(1'b0, 1'b1, 1'b1, $urandom, 1'b1, 1'b1, 1'b0, 1'b0, held_dr, held_raw);
    load_type = 3'd4;
    step(1'b0, 1'b0, 1'b1, $urandom, 1'b1, 1'b1, 1'b0, 1'b0, held_dr, held_raw);
    idle_zero(1'b1);
    idle_zero(1'b0);
    txn(4, 0, $urandom, 32'h0BAD_F00D, 0, 1, 1'b1, 32'h0BAD_F00D);

    // Timeout: slave stalls past the limit, ERR is sticky until reset.
    step(1'b0, 1'b1, 1'b1, $urandom, 1'b1, 1'b1, 1'b0, 1'b0, held_dr, held_raw);
    for (int k = 1; k <= MW; k++)
      step(1'b0, 1'b0, 1'b1, $urandom, 1'b1, 1'b1, 1'b0, 1'b0, held_dr, held_raw);
    step(1'b0, 1'b0, 1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b1, held_dr, held_raw);
    for (int k = 0; k < 4; k++)
      step(1'b0, 1'b1, 1'($urandom), $urandom, 1'b0, 1'b0, 1'b0, 1'b1, held_dr, held_raw);
    idle_zero(1'b1);
    idle_zero(1'b0);
    txn(0, 0, $urandom, 32'h0000_00FF, 1, 1, 1'b1, 32'hFFFF_FFFF);

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
